// File: rtl/march_bist_if.sv
// March C- BIST bus bundle: address-generator control and memory port.
// master = BIST controller, slave = address generator / memory under test.
interface march_bist_if #(
   parameter int Adr_size  = 4,
   parameter int Data_size = 8
) ();
   logic [Adr_size-1:0]  adr_in;
   logic                 adr_rst;
   logic                 adr_preset;
   logic                 adr_en;
   logic                 adr_up_down;
   logic                 mem_we;
   logic                 mem_re;
   logic [Data_size-1:0] mem_wdata;
   logic [Data_size-1:0] mem_rdata;

   modport master (
      input  adr_in, mem_rdata,
      output adr_rst, adr_preset, adr_en, adr_up_down,
      output mem_we, mem_re, mem_wdata
   );

   modport slave (
      output adr_in, mem_rdata,
      input  adr_rst, adr_preset, adr_en, adr_up_down,
      input  mem_we, mem_re, mem_wdata
   );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: clk, rst_n (async low), start; bus (master) to
// address generator and SRAM; busy/done/fail/fail_adr/fail_elem status.
// Optional BIST_FAIL_CNT_EN adds fail_cnt[7:0] (saturating mismatch count).
module march_bist_ctrl #(
   parameter int Adr_size  = 4,
   parameter int Data_size = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   march_bist_if.master        bus,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [Adr_size-1:0] fail_adr,
`ifdef BIST_FAIL_CNT_EN
   output logic [2:0]          fail_elem,
   output logic [7:0]          fail_cnt
`else
   output logic [2:0]          fail_elem
`endif
);

   typedef enum logic [2:0] {
      IDLE, INIT, OP, DRAIN, DONE
   } state_t;

   state_t               state, state_n;
   logic [2:0]           elem, elem_n;
   logic                 op_idx, op_n;
   logic                 cmp_pend;
   logic [Data_size-1:0] cmp_exp;
   logic [Adr_size-1:0]  cmp_adr;
   logic [2:0]           cmp_elem;

   logic up, one_op, last_op, term, rd_op, bg, mis;

   // M0..M2 ascend, M3..M5 descend; M0/M5 have a single op.
   // Two-op elements read bg then write ~bg; bg=1 for M2/M4.
   assign up      = (elem <= 3'd2);
   assign one_op  = (elem == 3'd0) || (elem == 3'd5);
   assign last_op = one_op || op_idx;
   assign term    = up ? (&bus.adr_in) : ~(|bus.adr_in);
   assign bg      = (elem == 3'd2) || (elem == 3'd4);
   assign rd_op   = (elem == 3'd5) || (!one_op && !op_idx);
   assign mis     = cmp_pend && (bus.mem_rdata != cmp_exp);

   always_comb begin
      state_n         = state;
      elem_n          = elem;
      op_n            = op_idx;
      busy            = 1'b0;
      done            = 1'b0;
      bus.adr_rst     = 1'b0;
      bus.adr_preset  = 1'b0;
      bus.adr_en      = 1'b0;
      bus.adr_up_down = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_re      = 1'b0;
      bus.mem_wdata   = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = INIT;
               elem_n  = 3'd0;
               op_n    = 1'b0;
            end
         end
         INIT: begin
            busy            = 1'b1;
            bus.adr_rst     = up;
            bus.adr_preset  = !up;
            bus.adr_up_down = up;
            state_n         = OP;
         end
         OP: begin
            busy            = 1'b1;
            bus.adr_up_down = up;
            if (rd_op) begin
               bus.mem_re = 1'b1;
            end else begin
               bus.mem_we    = 1'b1;
               bus.mem_wdata = {Data_size{(elem != 3'd0) && !bg}};
            end
            if (last_op) begin
               op_n = 1'b0;
               if (!term) begin
                  bus.adr_en = 1'b1;
               end else if (elem == 3'd5) begin
                  state_n = DRAIN;
               end else begin
                  elem_n  = elem + 3'd1;
                  state_n = INIT;
               end
            end else begin
               op_n = 1'b1;
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         elem   <= 3'd0;
         op_idx <= 1'b0;
      end else begin
         state  <= state_n;
         elem   <= elem_n;
         op_idx <= op_n;
      end
   end

   // Read data arrives one cycle after mem_re; keep what to compare it with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_pend <= 1'b0;
         cmp_exp  <= '0;
         cmp_adr  <= '0;
         cmp_elem <= 3'd0;
      end else begin
         cmp_pend <= bus.mem_re;
         cmp_exp  <= {Data_size{bg}};
         cmp_adr  <= bus.adr_in;
         cmp_elem <= elem;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail      <= 1'b0;
         fail_adr  <= '0;
         fail_elem <= 3'd0;
      end else if (state == IDLE && start) begin
         fail      <= 1'b0;
         fail_adr  <= '0;
         fail_elem <= 3'd0;
      end else if (mis && !fail) begin
         fail      <= 1'b1;
         fail_adr  <= cmp_adr;
         fail_elem <= cmp_elem;
      end
   end

`ifdef BIST_FAIL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_cnt <= 8'd0;
      end else if (state == IDLE && start) begin
         fail_cnt <= 8'd0;
      end else if (mis && fail_cnt != 8'hff) begin
         fail_cnt <= fail_cnt + 8'd1;
      end
   end
`endif

endmodule
